mem_scan_checker: RTL and testbench
===================================

# mem_scan_checker

Sequential scanner that sits directly upstream of the 32x32 synchronous-read word memory: it drives the memory's read address and consumes the registered read data one cycle later. One full scan of every address reports three results: the count and first address of all-zero words, the OR of all data bits, and the first word whose bits overlap bits already seen. Results are presented through a valid/ready handshake to the control logic.

## Interface
- `ADDR_W`, 5, memory address width; scan depth DEPTH = 2**ADDR_W
- `DATA_W`, 32, memory word width

- `clk`  in  1  single clock, all state on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  scan request, sampled only in IDLE
- `busy`  out  1  high whenever state != IDLE
- `addr`  out  ADDR_W  read address to memory (registered)
- `rd_data`  in  DATA_W  memory registered read data (1-cycle latency)
- `done_valid`  out  1  results valid, held until accepted
- `done_ready`  in  1  consumer accepts results
- `zero_cnt`  out  ADDR_W+1  number of words equal to 0
- `zero_seen`  out  1  zero_cnt != 0
- `first_zero_addr`  out  ADDR_W  lowest address holding 0
- `used_bits`  out  DATA_W  OR of all scanned words
- `overlap_err`  out  1  some word shared a bit with earlier words
- `overlap_addr`  out  ADDR_W  first address raising overlap_err

## Operation
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE: `start`=1 at edge T -> SCAN; all result registers cleared at T; `addr`=0.
- SCAN: `addr` increments by 1 each cycle from 0 to DEPTH-1; after `addr`=DEPTH-1 -> DRAIN (no wrap issue, addr returns to 0).
- Capture pipeline: 1-bit `cap_v` and `cap_addr` delayed one cycle behind `addr`; rd_data is sampled when `cap_v`=1 and attributed to `cap_addr`.
- Per sample w at address a: if w==0: zero_cnt++, first_zero_addr=a if first; if (w & used_bits)!=0 and !overlap_err: overlap_err=1, overlap_addr=a; then used_bits |= w.
- DRAIN: one cycle, consumes final word -> REPORT.
- REPORT: `done_valid`=1; on `done_valid && done_ready` -> IDLE.
- Results hold their values in REPORT and after return to IDLE, until next accepted `start`.
- `start` in SCAN/DRAIN/REPORT ignored (not queued).
- zero_cnt width ADDR_W+1 so DEPTH (32) is representable; no saturation needed.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, `addr`=0, `busy`=0, `done_valid`=0, all result outputs 0, `cap_v`=0.
- Reset mid-scan aborts immediately; no partial results survive.
- With start sampled at edge T: addr i driven T+i..T+i+1; memory registers word at T+i+1; checker accumulates at T+i+2.
- Last accumulation and `done_valid` rise at edge T+DEPTH+1 (33 for DEPTH=32); `busy` high from T through handshake edge.
- Handshake edge: `done_valid` drops the following cycle; earliest new `start` sampled one cycle after return to IDLE.
- `done_ready` held high in advance: REPORT lasts exactly one cycle.

## Configuration
- `MEM_SCAN_OVERLAP_EN` defined: overlap detection built; `overlap_err`/`overlap_addr` as above.
- Undefined: overlap logic removed; `overlap_err`=0, `overlap_addr`=0 constantly; all other behaviour and timing unchanged.

## Test plan
- mem[i]=1<<i, start pulse -> done_valid at T+33; zero_cnt=0, zero_seen=0, used_bits=0xFFFFFFFF, overlap_err=0.
- All words 0 -> zero_cnt=32, first_zero_addr=0, used_bits=0, overlap_err=0.
- mem[i]=1<<i except mem[7]=0x1 and mem[20]=0 -> overlap_err=1, overlap_addr=7, zero_cnt=1, first_zero_addr=20, used_bits=0xFFEFFF7F (bits 7 and 20 clear).
- done_ready low 10 cycles in REPORT, start pulsed during SCAN and REPORT -> outputs stable, only one scan occurs, busy low one cycle after handshake.
- rst_n low at cycle T+10 -> addr=0, busy=0, done_valid=0, results 0 asynchronously; new start then yields full correct scan.
- Build without MEM_SCAN_OVERLAP_EN, repeat third case -> overlap_err=0, overlap_addr=0, other results identical.

Source files
------------

// File: rtl/mem_scan_checker_if.sv
// ============================================================================
// mem_scan_checker_if
// Bus between the scan checker, its word memory and the control logic.
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_scan_checker_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic              done_valid;
  logic              done_ready;
  logic [ADDR_W:0]   zero_cnt;
  logic              zero_seen;
  logic [ADDR_W-1:0] first_zero_addr;
  logic [DATA_W-1:0] used_bits;
  logic              overlap_err;
  logic [ADDR_W-1:0] overlap_addr;

  // Checker side.
  modport slave (
    input  start,
    input  rd_data,
    input  done_ready,
    output busy,
    output addr,
    output done_valid,
    output zero_cnt,
    output zero_seen,
    output first_zero_addr,
    output used_bits,
    output overlap_err,
    output overlap_addr
  );

  // Control logic / memory side.
  modport master (
    output start,
    output rd_data,
    output done_ready,
    input  busy,
    input  addr,
    input  done_valid,
    input  zero_cnt,
    input  zero_seen,
    input  first_zero_addr,
    input  used_bits,
    input  overlap_err,
    input  overlap_addr
  );

endinterface

`default_nettype wire

// File: rtl/mem_scan_checker.sv
// ============================================================================
// mem_scan_checker
// Scans every word of a synchronous-read memory and reports zero-word,
// bit-usage and bit-overlap results. Optional macro: MEM_SCAN_OVERLAP_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_scan_checker #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_scan_checker_if.slave    bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cap_v_q, cap_v_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [ADDR_W:0]   zero_cnt_q, zero_cnt_d;
  logic [ADDR_W-1:0] first_zero_addr_q, first_zero_addr_d;
  logic [DATA_W-1:0] used_bits_q, used_bits_d;
  logic              scan_start;

  assign scan_start = (state_q == IDLE) && bus.start;

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    cap_v_d           = 1'b0;
    cap_addr_d        = cap_addr_q;
    zero_cnt_d        = zero_cnt_q;
    first_zero_addr_d = first_zero_addr_q;
    used_bits_d       = used_bits_q;

    // cap_v_q is only ever set during SCAN/DRAIN, so this never collides
    // with the result clear on scan_start below.
    if (cap_v_q) begin
      if (bus.rd_data == '0) begin
        zero_cnt_d = zero_cnt_q + CNT_ONE;
        if (zero_cnt_q == '0) begin
          first_zero_addr_d = cap_addr_q;
        end
      end
      used_bits_d = used_bits_q | bus.rd_data;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d           = SCAN;
          addr_d            = '0;
          zero_cnt_d        = '0;
          first_zero_addr_d = '0;
          used_bits_d       = '0;
        end
      end
      SCAN: begin
        cap_v_d    = 1'b1;
        cap_addr_d = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      DRAIN: begin
        state_d = REPORT;
      end
      REPORT: begin
        if (bus.done_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      addr_q            <= '0;
      cap_v_q           <= 1'b0;
      cap_addr_q        <= '0;
      zero_cnt_q        <= '0;
      first_zero_addr_q <= '0;
      used_bits_q       <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      cap_v_q           <= cap_v_d;
      cap_addr_q        <= cap_addr_d;
      zero_cnt_q        <= zero_cnt_d;
      first_zero_addr_q <= first_zero_addr_d;
      used_bits_q       <= used_bits_d;
    end
  end

`ifdef MEM_SCAN_OVERLAP_EN
  logic              overlap_err_q, overlap_err_d;
  logic [ADDR_W-1:0] overlap_addr_q, overlap_addr_d;

  // Compare against used_bits_q before this word is folded in, so a word
  // never overlaps with itself; only the first offender is latched.
  always_comb begin
    overlap_err_d  = overlap_err_q;
    overlap_addr_d = overlap_addr_q;
    if (scan_start) begin
      overlap_err_d  = 1'b0;
      overlap_addr_d = '0;
    end else if (cap_v_q && !overlap_err_q &&
                 ((bus.rd_data & used_bits_q) != '0)) begin
      overlap_err_d  = 1'b1;
      overlap_addr_d = cap_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlap_err_q  <= 1'b0;
      overlap_addr_q <= '0;
    end else begin
      overlap_err_q  <= overlap_err_d;
      overlap_addr_q <= overlap_addr_d;
    end
  end

  assign bus.overlap_err  = overlap_err_q;
  assign bus.overlap_addr = overlap_addr_q;
`else
  assign bus.overlap_err  = 1'b0;
  assign bus.overlap_addr = '0;
`endif

  assign bus.busy            = (state_q != IDLE);
  assign bus.done_valid      = (state_q == REPORT);
  assign bus.addr            = addr_q;
  assign bus.zero_cnt        = zero_cnt_q;
  assign bus.zero_seen       = (zero_cnt_q != '0);
  assign bus.first_zero_addr = first_zero_addr_q;
  assign bus.used_bits       = used_bits_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_scan_checker.sv
// ============================================================================
// tb_mem_scan_checker
// Directed and randomized scans against a whole-array reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_scan_checker;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst_n;

  mem_scan_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_scan_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  always @(posedge clk) bus.rd_data <= mem[bus.addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          exp_zc;
  int          exp_fz;
  logic [31:0] exp_used;
  logic        exp_ov;
  int          exp_oa;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the whole array in address order applying the scan rules.
  task automatic compute_model();
    logic found;
    exp_zc = 0; exp_fz = 0; exp_used = '0; exp_ov = 1'b0; exp_oa = 0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] == 32'h0) begin
        exp_zc++;
        if (!found) exp_fz = i;
        found = 1'b1;
      end
      if (((mem[i] & exp_used) != 32'h0) && !exp_ov) begin
        exp_ov = 1'b1;
        exp_oa = i;
      end
      exp_used = exp_used | mem[i];
    end
`ifndef MEM_SCAN_OVERLAP_EN
    exp_ov = 1'b0;
    exp_oa = 0;
`endif
  endtask

  task automatic check_results(input string tag);
    check({tag, ".zero_cnt"},  64'(bus.zero_cnt),        64'(exp_zc));
    check({tag, ".zero_seen"}, 64'(bus.zero_seen),       64'(exp_zc != 0));
    check({tag, ".first_z"},   64'(bus.first_zero_addr), 64'(exp_fz));
    check({tag, ".used"},      64'(bus.used_bits),       64'(exp_used));
    check({tag, ".ov_err"},    64'(bus.overlap_err),     64'(exp_ov));
    check({tag, ".ov_addr"},   64'(bus.overlap_addr),    64'(exp_oa));
  endtask

  // Pulses start (edge T), then waits for done_valid; returns edges after T.
  task automatic start_and_wait(input int start_pulse_at, output int cyc);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start.busy", 64'(bus.busy), 64'd1);
    cyc = 0;
    while (!bus.done_valid && cyc < 100) begin
      bus.start = (cyc == start_pulse_at);
      step();
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      case ($urandom_range(0, 3))
        0:       mem[i] = 32'h0;
        1:       mem[i] = 32'h1 << $urandom_range(0, 31);
        default: mem[i] = $urandom & $urandom & $urandom;
      endcase
    end
  endtask

  initial begin
    int cyc;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.done_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    #12;
    check("rst.busy",  64'(bus.busy),       64'd0);
    check("rst.addr",  64'(bus.addr),       64'd0);
    check("rst.valid", 64'(bus.done_valid), 64'd0);
    check("rst.zc",    64'(bus.zero_cnt),   64'd0);
    check("rst.used",  64'(bus.used_bits),  64'd0);
    check("rst.ov",    64'(bus.overlap_err), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // One-hot words: full coverage, no zeros, no overlap.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1 << i;
    compute_model();
    start_and_wait(-1, cyc);
    check("onehot.latency", 64'(cyc), 64'd33);
    check("onehot.used_lit", 64'(bus.used_bits), 64'hFFFF_FFFF);
    check_results("onehot");
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    check("onehot.valid_drop", 64'(bus.done_valid), 64'd0);
    check("onehot.busy_drop",  64'(bus.busy),       64'd0);

    // All zero words.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    compute_model();
    step();
    start_and_wait(-1, cyc);
    check("zero.latency", 64'(cyc), 64'd33);
    check("zero.zc_lit",  64'(bus.zero_cnt), 64'd32);
    check_results("zero");
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;

    // Overlap at 7, single zero at 20.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1 << i;
    mem[7]  = 32'h1;
    mem[20] = 32'h0;
    compute_model();
    step();
    start_and_wait(-1, cyc);
    check("ovl.used_lit", 64'(bus.used_bits),       64'hFFEF_FF7F);
    check("ovl.fz_lit",   64'(bus.first_zero_addr), 64'd20);
`ifdef MEM_SCAN_OVERLAP_EN
    check("ovl.oa_lit",   64'(bus.overlap_addr),    64'd7);
`else
    check("ovl.oa_lit",   64'(bus.overlap_addr),    64'd0);
`endif
    check_results("ovl");

    // Hold in REPORT with ready low; start pulses in SCAN and REPORT ignored.
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    fill_random();
    compute_model();
    step();
    start_and_wait(5, cyc);
    check("hold.latency", 64'(cyc), 64'd33);
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 4);
      step();
      check("hold.valid", 64'(bus.done_valid), 64'd1);
      check("hold.zc",    64'(bus.zero_cnt),   64'(exp_zc));
      check("hold.used",  64'(bus.used_bits),  64'(exp_used));
    end
    bus.start      = 1'b0;
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;
    check("hold.busy_after", 64'(bus.busy), 64'd0);
    step();
    step();
    check("hold.no_queue", 64'(bus.busy), 64'd0);
    check_results("hold.idle");

    // Reset ten cycles into a scan.
    fill_random();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    rst_n = 1'b0;
    #1;
    check("mid.addr",  64'(bus.addr),       64'd0);
    check("mid.busy",  64'(bus.busy),       64'd0);
    check("mid.valid", 64'(bus.done_valid), 64'd0);
    check("mid.zc",    64'(bus.zero_cnt),   64'd0);
    check("mid.fz",    64'(bus.first_zero_addr), 64'd0);
    check("mid.used",  64'(bus.used_bits),  64'd0);
    check("mid.oa",    64'(bus.overlap_addr), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    compute_model();
    start_and_wait(-1, cyc);
    check("mid.rescan_latency", 64'(cyc), 64'd33);
    check_results("mid.rescan");
    bus.done_ready = 1'b1;
    step();
    bus.done_ready = 1'b0;

    // Random scans, ready sometimes held high in advance.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      compute_model();
      bus.done_ready = t[0];
      step();
      start_and_wait(-1, cyc);
      check("rnd.latency", 64'(cyc), 64'd33);
      check_results("rnd");
      bus.done_ready = 1'b1;
      step();
      check("rnd.one_cycle_report", 64'(bus.done_valid), 64'd0);
      bus.done_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
